// File: rtl/audio_sos_coef_sched_pkg.sv
// Shared definitions for the biquad coefficient scheduler: command word layout,
// opcodes, scheduler states and status bit positions.
package audio_sos_pkg;

  localparam int          COEF_W = 16;
  localparam logic [15:0] UNITY  = 16'h4000;

  // Command word layout
  localparam int CMD_W   = 24;
  localparam int TOG_BIT = 23;
  localparam int OP_HI   = 22;
  localparam int OP_LO   = 21;
  localparam int IDX_HI  = 20;
  localparam int IDX_LO  = 16;
  localparam int DATA_HI = 15;
  localparam int DATA_LO = 0;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_WRITE  = 2'b01,
    OP_COMMIT = 2'b10,
    OP_CLEAR  = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SYNC  = 2'd2
  } sched_state_e;

  // Status word bit positions
  localparam int STAT_BUSY       = 0;
  localparam int STAT_PENDING    = 1;
  localparam int STAT_ERR_DROP   = 2;
  localparam int STAT_ERR_INDEX  = 3;
  localparam int STAT_ACTIVE_SEL = 4;

  // Coefficient k of each section sits at index 5*s+k; k == 0 is b0.
  function automatic logic is_b0(input int idx);
    return (idx % 5) == 0;
  endfunction

endpackage

// File: rtl/audio_sos_coef_sched_if.sv
// Software/datapath-facing bundle of the coefficient scheduler: PIO command and
// status words, sample tick, and the active-bank read port.
interface audio_sos_coef_sched_if #(
  parameter int COEF_W = audio_sos_pkg::COEF_W
);
  logic [audio_sos_pkg::CMD_W-1:0] pio_word;
  logic                            sample_tick;
  logic [4:0]                      coef_rd_addr;
  logic [COEF_W-1:0]               coef_rd_data;
  logic                            commit_done;
  logic [7:0]                      status;

  modport master (
    output pio_word, sample_tick, coef_rd_addr,
    input  coef_rd_data, commit_done, status
  );

  modport slave (
    input  pio_word, sample_tick, coef_rd_addr,
    output coef_rd_data, commit_done, status
  );
endinterface

// File: rtl/audio_sos_coef_bank.sv
// Two coefficient banks: one write port into the selected bank (direct data or a
// copy from the other bank at the same index) and a registered read port.
module audio_sos_coef_bank #(
  parameter int                NCOEF  = 20,
  parameter int                COEF_W = 16,
  parameter logic [COEF_W-1:0] UNITY  = 16'h4000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_sel,
  input  logic [4:0]        rd_addr,
  output logic [COEF_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic              wr_copy,
  input  logic [4:0]        wr_addr,
  input  logic [COEF_W-1:0] wr_data
);
  import audio_sos_pkg::*;

  localparam logic [5:0] NCOEF_V = 6'(NCOEF);

  logic [COEF_W-1:0] mem [2][NCOEF];

  // NOTE: the banks are flops rather than a RAM because both must come out of
  // reset holding passthrough coefficients, so every entry gets a reset value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NCOEF; i++) begin
          mem[b][i] <= is_b0(i) ? UNITY : '0;
        end
      end
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_sel][wr_addr] <= wr_copy ? mem[~wr_sel][wr_addr] : wr_data;
      end
      rd_data <= ({1'b0, rd_addr} < NCOEF_V) ? mem[rd_sel][rd_addr] : '0;
    end
  end

endmodule

// File: rtl/audio_sos_coef_sched.sv
// Biquad coefficient scheduler: decodes toggle-framed PIO commands into the
// shadow bank and swaps shadow/active atomically on an audio sample tick.
module audio_sos_coef_sched #(
  parameter int                NSEC   = 4,
  parameter int                COEF_W = audio_sos_pkg::COEF_W,
  parameter logic [COEF_W-1:0] UNITY  = audio_sos_pkg::UNITY
) (
  input logic                   clk,
  input logic                   reset_n,
  audio_sos_coef_sched_if.slave bus
);
  import audio_sos_pkg::*;

  localparam int         NCOEF    = 5 * NSEC;
  localparam logic [5:0] NCOEF_V  = 6'(NCOEF);
  localparam logic [4:0] LAST_IDX = 5'(NCOEF - 1);

  // Command capture pipeline
  logic [CMD_W-1:0]  word_q;
  logic              tog_prev;
  logic              cmd_valid;
  opcode_e           cmd_op;
  logic [4:0]        cmd_idx;
  logic [COEF_W-1:0] cmd_data;

  // Scheduler state
  sched_state_e      state;
  logic [4:0]        cnt;
  logic              active_sel;
  logic              commit_pending;
  logic              err_drop;
  logic              err_index;
  logic              commit_done_q;

  logic              swap;
  logic              idx_ok;
  logic              wr_en;
  logic              wr_copy;
  logic [4:0]        wr_addr;
  logic [COEF_W-1:0] wr_data;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q    <= '0;
      tog_prev  <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_op    <= OP_NOP;
      cmd_idx   <= '0;
      cmd_data  <= '0;
    end else begin
      word_q    <= bus.pio_word;
      tog_prev  <= word_q[TOG_BIT];
      cmd_valid <= word_q[TOG_BIT] ^ tog_prev;
      cmd_op    <= opcode_e'(word_q[OP_HI:OP_LO]);
      cmd_idx   <= word_q[IDX_HI:IDX_LO];
      cmd_data  <= COEF_W'(word_q[DATA_HI:DATA_LO]);
    end
  end

  assign idx_ok = ({1'b0, cmd_idx} < NCOEF_V);
  // A pending commit on a tick outranks a command detected in the same cycle.
  assign swap   = (state == IDLE) && commit_pending && bus.sample_tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      active_sel     <= 1'b0;
      commit_pending <= 1'b0;
      err_drop       <= 1'b0;
      err_index      <= 1'b0;
      commit_done_q  <= 1'b0;
    end else begin
      commit_done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (swap) begin
            active_sel     <= ~active_sel;
            commit_done_q  <= 1'b1;
            commit_pending <= 1'b0;
            state          <= SYNC;
            if (cmd_valid) err_drop <= 1'b1;
          end else if (cmd_valid) begin
            unique case (cmd_op)
              OP_NOP: begin
                err_drop  <= 1'b0;
                err_index <= 1'b0;
              end
              OP_WRITE:  if (!idx_ok) err_index <= 1'b1;
              OP_COMMIT: commit_pending <= 1'b1;
              OP_CLEAR:  state <= CLEAR;
              default: ;
            endcase
          end
        end
        CLEAR, SYNC: begin
          if (cmd_valid) err_drop <= 1'b1;
          if (cnt == LAST_IDX) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shadow-bank write port: accepted WRITEs in IDLE, passthrough fill in CLEAR,
  // active-to-shadow copy in SYNC.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    wr_en   = 1'b0;
    wr_copy = 1'b0;
    wr_addr = cmd_idx;
    wr_data = cmd_data;
    unique case (state)
      IDLE:  wr_en = cmd_valid && !swap && (cmd_op == OP_WRITE) && idx_ok;
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cnt;
        wr_data = is_b0(int'(cnt)) ? UNITY : '0;
      end
      SYNC: begin
        wr_en   = 1'b1;
        wr_copy = 1'b1;
        wr_addr = cnt;
      end
      default: ;
    endcase
  end

  audio_sos_coef_bank #(
    .NCOEF  (NCOEF),
    .COEF_W (COEF_W),
    .UNITY  (UNITY)
  ) u_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .rd_sel  (active_sel),
    .rd_addr (bus.coef_rd_addr),
    .rd_data (bus.coef_rd_data),
    .wr_en   (wr_en),
    .wr_sel  (~active_sel),
    .wr_copy (wr_copy),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  always_comb begin
    bus.status                  = '0;
    bus.status[STAT_BUSY]       = (state != IDLE);
    bus.status[STAT_PENDING]    = commit_pending;
    bus.status[STAT_ERR_DROP]   = err_drop;
    bus.status[STAT_ERR_INDEX]  = err_index;
    bus.status[STAT_ACTIVE_SEL] = active_sel;
  end

  assign bus.commit_done = commit_done_q;

endmodule

// File: tb/tb_audio_sos_coef_sched.sv
// Self-checking bench for audio_sos_coef_sched against a bank-level model:
// active/shadow arrays, a pending flag and error flags updated per command.
module tb_audio_sos_coef_sched;

  localparam int          NSEC   = 4;
  localparam int          NCOEF  = 5 * NSEC;
  localparam int          COEF_W = 16;
  localparam logic [15:0] UNITY  = 16'h4000;

  localparam logic [1:0] C_NOP    = 2'b00;
  localparam logic [1:0] C_WRITE  = 2'b01;
  localparam logic [1:0] C_COMMIT = 2'b10;
  localparam logic [1:0] C_CLEAR  = 2'b11;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  audio_sos_coef_sched_if #(.COEF_W(COEF_W)) bus ();

  audio_sos_coef_sched #(
    .NSEC   (NSEC),
    .COEF_W (COEF_W),
    .UNITY  (UNITY)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        tog = 1'b0;
  logic [15:0] m_act [NCOEF];
  logic [15:0] m_shd [NCOEF];
  logic        m_sel, m_pend, m_edrop, m_eidx;
  logic [15:0] rb [32];

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < NCOEF; i++) begin
      m_act[i] = (i % 5 == 0) ? UNITY : 16'h0000;
      m_shd[i] = m_act[i];
    end
    m_sel = 1'b0; m_pend = 1'b0; m_edrop = 1'b0; m_eidx = 1'b0;
  endtask

  task automatic model_cmd(input logic [1:0] op, input logic [4:0] idx, input logic [15:0] data);
    case (op)
      C_NOP:    begin m_edrop = 1'b0; m_eidx = 1'b0; end
      C_WRITE:  if (int'(idx) < NCOEF) m_shd[idx] = data; else m_eidx = 1'b1;
      C_COMMIT: m_pend = 1'b1;
      default:  for (int i = 0; i < NCOEF; i++) m_shd[i] = (i % 5 == 0) ? UNITY : 16'h0000;
    endcase
  endtask

  // Swap: the shadow becomes active, and the new shadow is a copy of it.
  task automatic model_swap();
    for (int i = 0; i < NCOEF; i++) m_act[i] = m_shd[i];
    m_sel  = ~m_sel;
    m_pend = 1'b0;
  endtask

  function automatic logic [7:0] exp_status(input logic busy);
    return {3'b000, m_sel, m_eidx, m_edrop, m_pend, busy};
  endfunction

  function automatic logic [15:0] exp_rd(input int a);
    return (a < NCOEF) ? m_act[a] : 16'h0000;
  endfunction

  // ---------------- stimulus helpers (no comparisons) ----------------
  task automatic send_word(input logic [1:0] op, input logic [4:0] idx, input logic [15:0] data);
    @(negedge clk);
    tog = ~tog;
    bus.pio_word = {tog, op, idx, data};
    repeat (3) @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] idx, input logic [15:0] data);
    send_word(op, idx, data);
    model_cmd(op, idx, data);
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.status[0] && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_bank();
    for (int a = 0; a < 32; a++) begin
      bus.coef_rd_addr = 5'(a);
      @(negedge clk);
      rb[a] = bus.coef_rd_data;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.pio_word = '0; bus.sample_tick = 1'b0; bus.coef_rd_addr = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.status !== 8'h00) begin errors++; $display("FAIL reset_status: got %h want 00", bus.status); end
    checks++; if (bus.commit_done !== 1'b0) begin errors++; $display("FAIL reset_commit_done: got %b want 0", bus.commit_done); end
    checks++; if (bus.coef_rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0000", bus.coef_rd_data); end
    reset_n = 1'b1;
    model_reset();
    read_bank();
    for (int a = 0; a < 32; a++) begin
      checks++; if (rb[a] !== exp_rd(a)) begin errors++; $display("FAIL reset_bank[%0d]: got %h want %h", a, rb[a], exp_rd(a)); end
    end
  endtask

  task automatic test_basic_commit();
    int n;
    issue(C_WRITE, 5'd0, 16'h2000);
    checks++; if (bus.status !== exp_status(1'b0)) begin errors++; $display("FAIL basic_write_status: got %h want %h", bus.status, exp_status(1'b0)); end
    bus.coef_rd_addr = 5'd0;
    @(negedge clk); @(negedge clk);
    checks++; if (bus.coef_rd_data !== 16'h4000) begin errors++; $display("FAIL basic_pre_commit_rd: got %h want 4000", bus.coef_rd_data); end
    // COMMIT: pending must appear exactly after the third edge
    @(negedge clk);
    tog = ~tog;
    bus.pio_word = {tog, C_COMMIT, 5'd0, 16'h0000};
    @(negedge clk); @(negedge clk);
    checks++; if (bus.status[1] !== 1'b0) begin errors++; $display("FAIL basic_commit_early: pending=%b want 0", bus.status[1]); end
    @(negedge clk);
    checks++; if (bus.status[1] !== 1'b1) begin errors++; $display("FAIL basic_commit_latency: pending=%b want 1", bus.status[1]); end
    model_cmd(C_COMMIT, 5'd0, 16'h0000);
    repeat (10) @(negedge clk);
    pulse_tick();
    model_swap();
    checks++; if (bus.commit_done !== 1'b1) begin errors++; $display("FAIL basic_commit_done: got %b want 1", bus.commit_done); end
    checks++; if (bus.status !== exp_status(1'b1)) begin errors++; $display("FAIL basic_swap_status: got %h want %h", bus.status, exp_status(1'b1)); end
    checks++; if (bus.coef_rd_data !== 16'h4000) begin errors++; $display("FAIL basic_rd_at_tick: got %h want 4000", bus.coef_rd_data); end
    @(negedge clk);
    checks++; if (bus.commit_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse_width: got %b want 0", bus.commit_done); end
    checks++; if (bus.coef_rd_data !== 16'h2000) begin errors++; $display("FAIL basic_rd_after_swap: got %h want 2000", bus.coef_rd_data); end
    wait_idle(n);
    checks++; if (n + 1 !== NCOEF) begin errors++; $display("FAIL basic_sync_busy_len: got %0d want %0d", n + 1, NCOEF); end
  endtask

  task automatic test_out_of_range();
    issue(C_WRITE, 5'd25, 16'h1234);
    checks++; if (bus.status !== exp_status(1'b0)) begin errors++; $display("FAIL oor_status: got %h want %h", bus.status, exp_status(1'b0)); end
    read_bank();
    for (int a = 0; a < 32; a++) begin
      checks++; if (rb[a] !== exp_rd(a)) begin errors++; $display("FAIL oor_bank[%0d]: got %h want %h", a, rb[a], exp_rd(a)); end
    end
    issue(C_NOP, 5'd0, 16'h0000);
    checks++; if (bus.status !== exp_status(1'b0)) begin errors++; $display("FAIL oor_nop_clear: got %h want %h", bus.status, exp_status(1'b0)); end
  endtask

  task automatic test_busy_drop();
    int n;
    issue(C_WRITE, 5'd3, 16'($urandom));
    issue(C_COMMIT, 5'd0, 16'h0000);
    pulse_tick();
    model_swap();
    checks++; if (bus.commit_done !== 1'b1) begin errors++; $display("FAIL drop_commit_done: got %b want 1", bus.commit_done); end
    send_word(C_WRITE, 5'd4, 16'hBEEF);
    m_edrop = 1'b1;
    checks++; if (bus.status !== exp_status(1'b1)) begin errors++; $display("FAIL drop_status: got %h want %h", bus.status, exp_status(1'b1)); end
    wait_idle(n);
    issue(C_COMMIT, 5'd0, 16'h0000);
    pulse_tick();
    model_swap();
    wait_idle(n);
    read_bank();
    for (int a = 0; a < 32; a++) begin
      checks++; if (rb[a] !== exp_rd(a)) begin errors++; $display("FAIL drop_bank[%0d]: got %h want %h", a, rb[a], exp_rd(a)); end
    end
  endtask

  task automatic test_tick_not_idle();
    int n;
    issue(C_WRITE, 5'd5, 16'($urandom));
    issue(C_WRITE, 5'd6, 16'($urandom));
    issue(C_COMMIT, 5'd0, 16'h0000);
    issue(C_CLEAR, 5'd0, 16'h0000);
    checks++; if (bus.status !== exp_status(1'b1)) begin errors++; $display("FAIL tni_clear_status: got %h want %h", bus.status, exp_status(1'b1)); end
    repeat (4) @(negedge clk);
    pulse_tick();
    checks++; if (bus.commit_done !== 1'b0) begin errors++; $display("FAIL tni_no_swap: commit_done=%b want 0", bus.commit_done); end
    @(negedge clk);
    checks++; if (bus.status !== exp_status(1'b1)) begin errors++; $display("FAIL tni_still_pending: got %h want %h", bus.status, exp_status(1'b1)); end
    wait_idle(n);
    checks++; if (bus.status !== exp_status(1'b0)) begin errors++; $display("FAIL tni_idle_status: got %h want %h", bus.status, exp_status(1'b0)); end
    pulse_tick();
    model_swap();
    checks++; if (bus.commit_done !== 1'b1) begin errors++; $display("FAIL tni_late_swap: commit_done=%b want 1", bus.commit_done); end
    wait_idle(n);
    read_bank();
    for (int a = 0; a < 32; a++) begin
      checks++; if (rb[a] !== exp_rd(a)) begin errors++; $display("FAIL tni_bank[%0d]: got %h want %h", a, rb[a], exp_rd(a)); end
    end
  endtask

  task automatic test_collision();
    int n;
    issue(C_WRITE, 5'd7, 16'($urandom));
    issue(C_COMMIT, 5'd0, 16'h0000);
    // toggle so the detect cycle coincides with the tick
    @(negedge clk);
    tog = ~tog;
    bus.pio_word = {tog, C_WRITE, 5'd8, 16'h5A5A};
    @(negedge clk);
    @(negedge clk);
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    model_swap();
    m_edrop = 1'b1;
    checks++; if (bus.commit_done !== 1'b1) begin errors++; $display("FAIL coll_commit_done: got %b want 1", bus.commit_done); end
    checks++; if (bus.status !== exp_status(1'b1)) begin errors++; $display("FAIL coll_status: got %h want %h", bus.status, exp_status(1'b1)); end
    wait_idle(n);
    read_bank();
    for (int a = 0; a < 32; a++) begin
      checks++; if (rb[a] !== exp_rd(a)) begin errors++; $display("FAIL coll_bank[%0d]: got %h want %h", a, rb[a], exp_rd(a)); end
    end
  endtask

  task automatic test_random();
    int n, nw;
    logic [4:0]  idx;
    logic [15:0] data;
    for (int r = 0; r < 6; r++) begin
      issue(C_NOP, 5'd0, 16'h0000);
      checks++; if (bus.status !== exp_status(1'b0)) begin errors++; $display("FAIL rnd%0d_nop: got %h want %h", r, bus.status, exp_status(1'b0)); end
      pulse_tick();
      checks++; if (bus.commit_done !== 1'b0) begin errors++; $display("FAIL rnd%0d_idle_tick: commit_done=%b want 0", r, bus.commit_done); end
      if (r == 2) begin
        issue(C_CLEAR, 5'd0, 16'h0000);
        wait_idle(n);
        checks++; if (n !== NCOEF) begin errors++; $display("FAIL rnd%0d_clear_len: got %0d want %0d", r, n, NCOEF); end
      end
      nw = $urandom_range(3, 8);
      for (int w = 0; w < nw; w++) begin
        idx  = 5'($urandom_range(0, 23));
        data = 16'($urandom);
        issue(C_WRITE, idx, data);
        checks++; if (bus.status !== exp_status(1'b0)) begin errors++; $display("FAIL rnd%0d_write: got %h want %h", r, bus.status, exp_status(1'b0)); end
      end
      issue(C_COMMIT, 5'd0, 16'h0000);
      if (r == 1) issue(C_COMMIT, 5'd0, 16'h0000);
      repeat ($urandom_range(0, 6)) @(negedge clk);
      pulse_tick();
      model_swap();
      checks++; if (bus.commit_done !== 1'b1) begin errors++; $display("FAIL rnd%0d_commit_done: got %b want 1", r, bus.commit_done); end
      wait_idle(n);
      checks++; if (n !== NCOEF) begin errors++; $display("FAIL rnd%0d_sync_len: got %0d want %0d", r, n, NCOEF); end
      read_bank();
      for (int a = 0; a < 32; a++) begin
        checks++; if (rb[a] !== exp_rd(a)) begin errors++; $display("FAIL rnd%0d_bank[%0d]: got %h want %h", r, a, rb[a], exp_rd(a)); end
      end
    end
  endtask

  task automatic test_reset_mid_sync();
    int n;
    issue(C_WRITE, 5'd10, 16'($urandom));
    issue(C_WRITE, 5'd0, 16'($urandom));
    issue(C_COMMIT, 5'd0, 16'h0000);
    pulse_tick();
    repeat (6) @(negedge clk);
    #2;
    reset_n = 1'b0;
    tog = 1'b0;
    bus.pio_word = '0;
    #1;
    checks++; if (bus.status !== 8'h00) begin errors++; $display("FAIL rms_status: got %h want 00", bus.status); end
    checks++; if (bus.commit_done !== 1'b0) begin errors++; $display("FAIL rms_commit_done: got %b want 0", bus.commit_done); end
    checks++; if (bus.coef_rd_data !== 16'h0) begin errors++; $display("FAIL rms_rd_data: got %h want 0000", bus.coef_rd_data); end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    checks++; if (bus.status !== 8'h00) begin errors++; $display("FAIL rms_post_status: got %h want 00", bus.status); end
    read_bank();
    for (int a = 0; a < 32; a++) begin
      checks++; if (rb[a] !== exp_rd(a)) begin errors++; $display("FAIL rms_active[%0d]: got %h want %h", a, rb[a], exp_rd(a)); end
    end
    // the shadow bank must also be back to passthrough
    issue(C_COMMIT, 5'd0, 16'h0000);
    pulse_tick();
    model_swap();
    wait_idle(n);
    read_bank();
    for (int a = 0; a < 32; a++) begin
      checks++; if (rb[a] !== exp_rd(a)) begin errors++; $display("FAIL rms_shadow[%0d]: got %h want %h", a, rb[a], exp_rd(a)); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_commit();
    test_out_of_range();
    test_busy_drop();
    test_tick_not_idle();
    test_collision();
    test_random();
    test_reset_mid_sync();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_sos_coef_sched.md
# audio_sos_coef_sched

Coefficient scheduler for the biquad (second-order-section) audio filter chain. Decodes 24-bit command words that the NIOS II writes through its 24-bit audio SOS PIO output port into a shadow coefficient bank. On request, it commits the whole bank atomically to the active bank on an audio sample boundary. The active bank is served to the SOS datapath through a registered read port, and status is returned to software through a PIO input.

## Interface
Parameters:
- NSEC, 4: number of cascaded sections; NCOEF = 5*NSEC, maximum 32.
- COEF_W, 16: coefficient width, signed Q2.14.
- UNITY, 16'h4000: b0 value used for passthrough.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- pio_word  in  24  command word from the PIO out_port. Fields: [23] toggle, [22:21] opcode, [20:16] index, [15:0] data.
- sample_tick  in  1  one-cycle pulse at the audio sample rate.
- coef_rd_addr  in  5  active-bank read address from the SOS datapath.
- coef_rd_data  out  COEF_W  registered active-bank coefficient.
- commit_done  out  1  one-cycle pulse when a bank swap occurs.
- status  out  8  status word to a PIO input. Bits: [0] busy, [1] commit_pending, [2] err_drop, [3] err_index, [4] active_sel, [7:5] 0.

## Operation
- Coefficient layout: index 5*s+k holds section s coefficient k, with k = b0, b1, b2, a1, a2.
- Command capture:
  - pio_word[23] is registered every cycle.
  - A change of bit 23 versus the registered copy is a new command. This costs 1 cycle of detect latency.
  - Words whose bit 23 does not change are ignored.
- Opcodes:
  - 00 NOP: clears err_drop and err_index.
  - 01 WRITE: shadow[index] <= data. If index >= NCOEF, the write is discarded and err_index is set.
  - 10 COMMIT: sets commit_pending. A COMMIT while already pending has no further effect.
  - 11 CLEAR: sequentially loads passthrough values into the shadow bank (b0 = UNITY, all others 0).
- Two physical banks are selected by active_sel. The shadow bank is the bank not selected by active_sel.
- FSM states IDLE, CLEAR, SYNC:
  - IDLE, CLEAR command -> CLEAR. The counter runs 0..NCOEF-1 writing one entry per cycle, then returns to IDLE.
  - IDLE with commit_pending and sample_tick -> active_sel flips, commit_done pulses, commit_pending clears, state -> SYNC.
  - SYNC copies the new active bank into the new shadow bank, one entry per cycle for NCOEF cycles, then returns to IDLE.
- busy = (state != IDLE).
- Any command detected while busy is dropped and sets err_drop. Software polls busy.
- A WRITE accepted while commit_pending is set joins the pending commit.
- A sample_tick outside IDLE (during CLEAR or SYNC) does not swap. The commit stays pending until the first tick seen in IDLE.
- A sample_tick with commit_pending clear has no effect.
- A command detect and a sample_tick in the same IDLE cycle:
  - The swap takes priority.
  - The command is dropped, with err_drop set.
- Reset values:
  - Both banks hold passthrough coefficients.
  - active_sel = 0, state = IDLE.
  - status = 0, coef_rd_data = 0, commit_done = 0.
  - The registered toggle copy takes the reset value 0.
- Reset asserted mid-CLEAR or mid-SYNC returns immediately to all reset values. Any pending commit is lost.

## Timing
- Command effect: the pio_word toggle is registered at edge N, the change is detected in cycle N+1, and the shadow write, state change or pending flag is visible after edge N+2.
- Read port:
  - coef_rd_data at edge N+1 equals active[coef_rd_addr] sampled at edge N.
  - The read uses active_sel as it was before any flip at edge N.
  - Addresses >= NCOEF return 0.
- Swap: sample_tick high at edge N -> active_sel flips and commit_done is high for cycle N+1. A read addressed at edge N+1 returns new-bank data.
- Durations: CLEAR and SYNC each hold busy for exactly NCOEF cycles. The minimum command spacing is therefore NCOEF+2 cycles.

## Structure
- Package audio_sos_pkg:
  - opcode constants OP_NOP, OP_WRITE, OP_COMMIT, OP_CLEAR
  - field bit positions
  - COEF_W, UNITY
  - state enum IDLE/CLEAR/SYNC
  - status bit indices
- Sub-module audio_sos_coef_bank:
  - Contains the two register banks, the write port (bank select, addr, data) and the registered read port.
  - The scheduler drives it with its FSM and counter.

## Test plan
- Basic commit:
  - Stimulus: after reset, WRITE index 0 = 16'h2000, then COMMIT, then a sample_tick 10 cycles later.
  - Before the tick: coef_rd_addr 0 reads 16'h4000.
  - On the tick: commit_done pulses once.
  - After the tick: the read returns 16'h2000, and busy stays high for 20 cycles (NSEC=4).
- Out-of-range index:
  - Stimulus: WRITE index 25 = 16'h1234.
  - Response: err_index = 1, no bank change, and a read of address 25 returns 0. A following NOP clears the flag.
- Command while busy:
  - Stimulus: a WRITE toggled during SYNC.
  - Response: err_drop = 1. After SYNC, the shadow entry is unchanged, verified by a COMMIT followed by a readback.
- Tick while not IDLE:
  - Stimulus: CLEAR issued with a commit pending, and a tick arriving during CLEAR.
  - Response: no swap. The swap happens on the next tick, and all b0 values read 16'h4000.
- Same-cycle collision: command detect and sample_tick in the same cycle -> the swap occurs and err_drop is set.
- Reset mid-SYNC:
  - Stimulus: reset_n asserted mid-SYNC.
  - Response: status = 0, active_sel = 0, and every b0 reads 16'h4000 with all other coefficients 0.
